// File: rtl/dma_request_control.sv
// Request conditioning (sync, sense, mask, software requests) and HRQ/HLDA
// hold handshake feeding the DMA priority logic.
module dma_request_control #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] DREQ,
  input  logic       dreqActiveLow,
  input  logic       controllerDisable,
  input  logic       maskWrite,
  input  logic [3:0] maskData,
  input  logic       singleMaskWrite,
  input  logic [1:0] singleMaskChannel,
  input  logic       singleMaskBit,
  input  logic       softReqWrite,
  input  logic [1:0] softReqChannel,
  input  logic       softReqBit,
  input  logic [3:0] tcChannel,
  input  logic [3:0] autoinit,
  input  logic       HLDA,
  input  logic       transferDone,
  output logic [3:0] reqVector,
  output logic [3:0] statusReq,
  output logic       HRQ,
  output logic       assertDACK
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HLDA = 2'd1,
    ACTIVE    = 2'd2,
    RELEASE   = 2'd3
  } state_t;

  state_t     state;
  logic [3:0] sync_ff [SYNC_STAGES];
  logic [3:0] sync_req;
  logic [3:0] sense_req;
  logic [3:0] mask;
  logic [3:0] mask_next;
  logic [3:0] soft_req;
  logic [3:0] soft_req_next;

  // Synchronizer chain per DREQ bit
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_ff[i] <= 4'b0000;
    end else begin
      sync_ff[0] <= DREQ;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_ff[i] <= sync_ff[i-1];
    end
  end

  assign sync_req  = sync_ff[SYNC_STAGES-1];
  assign sense_req = dreqActiveLow ? ~sync_req : sync_req;

  // Later updates override earlier ones: TC auto-mask, bulk write, single write
  always_comb begin
    mask_next = mask;
    mask_next = mask_next | (tcChannel & ~autoinit);
    if (maskWrite) mask_next = maskData;
    if (singleMaskWrite) mask_next[singleMaskChannel] = singleMaskBit;
  end

  // A TC clear beats a software write to the same bit
  always_comb begin
    soft_req_next = soft_req;
    if (softReqWrite) soft_req_next[softReqChannel] = softReqBit;
    soft_req_next = soft_req_next & ~tcChannel;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mask     <= 4'b1111;
      soft_req <= 4'b0000;
    end else begin
      mask     <= mask_next;
      soft_req <= soft_req_next;
    end
  end

  assign reqVector = controllerDisable ? 4'b0000 : ((sense_req | soft_req) & ~mask);
  assign statusReq = reqVector;

  // Hold handshake; outputs are registered alongside the state
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      HRQ        <= 1'b0;
      assertDACK <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (reqVector != 4'b0000) begin
            state <= WAIT_HLDA;
            HRQ   <= 1'b1;
          end
        end
        WAIT_HLDA: begin
          if (controllerDisable || (!HLDA && reqVector == 4'b0000)) begin
            state <= IDLE;
            HRQ   <= 1'b0;
          end else if (HLDA) begin
            state      <= ACTIVE;
            assertDACK <= 1'b1;
          end
        end
        ACTIVE: begin
          if (controllerDisable) begin
            state      <= IDLE;
            HRQ        <= 1'b0;
            assertDACK <= 1'b0;
          end else if (transferDone) begin
            state      <= RELEASE;
            HRQ        <= 1'b0;
            assertDACK <= 1'b0;
          end
        end
        RELEASE: begin
          if (!HLDA) state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          HRQ        <= 1'b0;
          assertDACK <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_request_control.sv
// Directed bench for dma_request_control with hand-computed expectations.
module tb_dma_request_control;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] DREQ;
  logic       dreqActiveLow;
  logic       controllerDisable;
  logic       maskWrite;
  logic [3:0] maskData;
  logic       singleMaskWrite;
  logic [1:0] singleMaskChannel;
  logic       singleMaskBit;
  logic       softReqWrite;
  logic [1:0] softReqChannel;
  logic       softReqBit;
  logic [3:0] tcChannel;
  logic [3:0] autoinit;
  logic       HLDA;
  logic       transferDone;
  logic [3:0] reqVector;
  logic [3:0] statusReq;
  logic       HRQ;
  logic       assertDACK;

  int checks   = 0;
  int failures = 0;

  dma_request_control #(.SYNC_STAGES(2)) dut (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .dreqActiveLow(dreqActiveLow),
    .controllerDisable(controllerDisable), .maskWrite(maskWrite), .maskData(maskData),
    .singleMaskWrite(singleMaskWrite), .singleMaskChannel(singleMaskChannel),
    .singleMaskBit(singleMaskBit), .softReqWrite(softReqWrite),
    .softReqChannel(softReqChannel), .softReqBit(softReqBit), .tcChannel(tcChannel),
    .autoinit(autoinit), .HLDA(HLDA), .transferDone(transferDone),
    .reqVector(reqVector), .statusReq(statusReq), .HRQ(HRQ), .assertDACK(assertDACK)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; DREQ = 4'b0000; dreqActiveLow = 1'b0; controllerDisable = 1'b0;
    maskWrite = 1'b0; maskData = 4'b0000; singleMaskWrite = 1'b0;
    singleMaskChannel = 2'd0; singleMaskBit = 1'b0; softReqWrite = 1'b0;
    softReqChannel = 2'd0; softReqBit = 1'b0; tcChannel = 4'b0000;
    autoinit = 4'b0000; HLDA = 1'b0; transferDone = 1'b0;
    tick(); tick();
    RESET = 1'b0;
    check("rst_req",  reqVector, 4'b0000);
    check("rst_hrq",  {3'b0, HRQ}, 4'b0000);
    check("rst_dack", {3'b0, assertDACK}, 4'b0000);

    // Full handshake on DREQ[2]
    maskWrite = 1'b1; maskData = 4'b0000;
    tick();
    maskWrite = 1'b0;
    check("t1_req_idle", reqVector, 4'b0000);
    DREQ = 4'b0100;
    tick();
    check("t1_sync_lat", reqVector, 4'b0000);
    tick();
    check("t1_req", reqVector, 4'b0100);
    check("t1_status", statusReq, 4'b0100);
    check("t1_hrq_pre", {3'b0, HRQ}, 4'b0000);
    tick();
    check("t1_hrq", {3'b0, HRQ}, 4'b0001);
    check("t1_dack_pre", {3'b0, assertDACK}, 4'b0000);
    HLDA = 1'b1;
    tick();
    check("t1_dack", {3'b0, assertDACK}, 4'b0001);
    check("t1_hrq_act", {3'b0, HRQ}, 4'b0001);
    transferDone = 1'b1;
    tick();
    transferDone = 1'b0;
    check("t1_done_hrq", {3'b0, HRQ}, 4'b0000);
    check("t1_done_dack", {3'b0, assertDACK}, 4'b0000);
    tick();
    check("t1_rel_hold", {3'b0, HRQ}, 4'b0000);
    HLDA = 1'b0;
    tick();
    check("t1_idle_hrq", {3'b0, HRQ}, 4'b0000);
    tick();
    check("t1_rereq_hrq", {3'b0, HRQ}, 4'b0001);
    DREQ = 4'b0000;
    tick(); tick();
    check("t1_req_gone", reqVector, 4'b0000);
    check("t1_wait_hold", {3'b0, HRQ}, 4'b0001);
    tick();
    check("t1_abort_hrq", {3'b0, HRQ}, 4'b0000);

    // Reset with all DREQ high: everything masked
    DREQ = 4'b1111;
    do_reset();
    check("t2_rst_req", reqVector, 4'b0000);
    tick(); tick();
    check("t2_masked_req", reqVector, 4'b0000);
    check("t2_masked_hrq", {3'b0, HRQ}, 4'b0000);
    singleMaskWrite = 1'b1; singleMaskChannel = 2'd3; singleMaskBit = 1'b0;
    tick();
    singleMaskWrite = 1'b0;
    check("t2_single_unmask", reqVector, 4'b1000);
    check("t2_status", statusReq, 4'b1000);

    // Software requests and TC handling
    DREQ = 4'b0000;
    do_reset();
    maskWrite = 1'b1; maskData = 4'b0000;
    tick();
    maskWrite = 1'b0;
    softReqWrite = 1'b1; softReqChannel = 2'd1; softReqBit = 1'b1;
    tick();
    softReqWrite = 1'b0;
    check("t3_soft_req", reqVector, 4'b0010);
    tcChannel = 4'b0010; autoinit = 4'b0000;
    tick();
    tcChannel = 4'b0000;
    check("t3_tc_clear", reqVector, 4'b0000);
    softReqWrite = 1'b1; softReqChannel = 2'd1; softReqBit = 1'b1;
    tick();
    check("t3_tc_masked", reqVector, 4'b0000);
    softReqChannel = 2'd0;
    tick();
    softReqWrite = 1'b0;
    check("t3_soft_ch0", reqVector, 4'b0001);
    tcChannel = 4'b0001; autoinit = 4'b0001;
    tick();
    tcChannel = 4'b0000;
    check("t3_auto_soft_clr", reqVector, 4'b0000);
    softReqWrite = 1'b1; softReqChannel = 2'd0; softReqBit = 1'b1;
    tick();
    check("t3_auto_mask_kept", reqVector, 4'b0001);
    softReqChannel = 2'd2; tcChannel = 4'b0100; autoinit = 4'b0100;
    tick();
    softReqWrite = 1'b0; tcChannel = 4'b0000; autoinit = 4'b0000;
    check("t3_tc_beats_write", reqVector, 4'b0001);

    // Active-low sense and abort in WAIT_HLDA
    DREQ = 4'b1110;
    do_reset();
    tick(); tick();
    dreqActiveLow = 1'b1; maskWrite = 1'b1; maskData = 4'b0000;
    tick();
    maskWrite = 1'b0;
    check("t4_active_low", reqVector, 4'b0001);
    tick();
    check("t4_hrq", {3'b0, HRQ}, 4'b0001);
    DREQ = 4'b1111;
    tick(); tick();
    check("t4_req_drop", reqVector, 4'b0000);
    tick();
    check("t4_abort_hrq", {3'b0, HRQ}, 4'b0000);
    dreqActiveLow = 1'b0;
    #1;
    check("t4_sense_comb", reqVector, 4'b1111);
    controllerDisable = 1'b1;
    #1;
    check("t4_disable_req", reqVector, 4'b0000);
    controllerDisable = 1'b0;

    // Reset in the middle of a service
    DREQ = 4'b0000;
    do_reset();
    maskWrite = 1'b1; maskData = 4'b0000;
    softReqWrite = 1'b1; softReqChannel = 2'd2; softReqBit = 1'b1;
    tick();
    maskWrite = 1'b0; softReqWrite = 1'b0;
    check("t5_req", reqVector, 4'b0100);
    tick();
    HLDA = 1'b1;
    tick();
    check("t5_dack", {3'b0, assertDACK}, 4'b0001);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("t5_rst_hrq", {3'b0, HRQ}, 4'b0000);
    check("t5_rst_dack", {3'b0, assertDACK}, 4'b0000);
    check("t5_rst_req", reqVector, 4'b0000);
    softReqWrite = 1'b1; softReqChannel = 2'd3; softReqBit = 1'b1;
    tick();
    softReqWrite = 1'b0;
    check("t5_mask_set", reqVector, 4'b0000);
    tick();
    check("t5_no_hrq", {3'b0, HRQ}, 4'b0000);
    HLDA = 1'b0;

    // Explicit single-mask write beats the TC auto-mask; disable aborts ACTIVE
    do_reset();
    tcChannel = 4'b0001; autoinit = 4'b0000;
    singleMaskWrite = 1'b1; singleMaskChannel = 2'd0; singleMaskBit = 1'b0;
    tick();
    tcChannel = 4'b0000; singleMaskWrite = 1'b0;
    softReqWrite = 1'b1; softReqChannel = 2'd0; softReqBit = 1'b1;
    tick();
    softReqWrite = 1'b0;
    check("t6_write_wins", reqVector, 4'b0001);
    tick();
    HLDA = 1'b1;
    tick();
    check("t6_dack", {3'b0, assertDACK}, 4'b0001);
    controllerDisable = 1'b1;
    tick();
    controllerDisable = 1'b0;
    check("t6_dis_hrq", {3'b0, HRQ}, 4'b0000);
    check("t6_dis_dack", {3'b0, assertDACK}, 4'b0000);
    tick();
    check("t6_rereq_hrq", {3'b0, HRQ}, 4'b0001);
    HLDA = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/dma_request_control.md
# dma_request_control

Request-conditioning and bus-hold handshake stage directly upstream of the DMA priority logic. Synchronizes the four raw DREQ inputs, applies DREQ sense, the mask register and the software request register, and presents the conditioned request vector to the priority logic. Runs the HRQ/HLDA hold handshake with the CPU and asserts `assertDACK`, the qualifier that lets the priority logic drive DACK, for the duration of a service.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop stages on each DREQ bit; legal range ≥2.

Ports:
- `CLK`  in  1  system clock; all state updates on its rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `DREQ`  in  4  raw channel requests, asynchronous to `CLK`.
- `dreqActiveLow`  in  1  DREQ sense from the command register: 1 means a low level requests.
- `controllerDisable`  in  1  command-register disable bit.
- `maskWrite`  in  1  load all four mask bits from `maskData`.
- `maskData`  in  4  mask value.
- `singleMaskWrite`  in  1  write one mask bit.
- `singleMaskChannel`  in  2  channel for the single-bit mask write.
- `singleMaskBit`  in  1  value for the single-bit mask write.
- `softReqWrite`  in  1  write one software request bit.
- `softReqChannel`  in  2  channel for the software request write.
- `softReqBit`  in  1  value for the software request write.
- `tcChannel`  in  4  one-hot, one-cycle terminal-count pulse.
- `autoinit`  in  4  per-channel autoinitialize mode bits.
- `HLDA`  in  1  hold acknowledge from the CPU.
- `transferDone`  in  1  one-cycle pulse marking the end of the current service.
- `reqVector`  out  4  conditioned requests to the priority logic.
- `statusReq`  out  4  request bits for the status register (equal to `reqVector`).
- `HRQ`  out  1  hold request to the CPU.
- `assertDACK`  out  1  DACK enable to the priority logic.

## Operation
- Request synchronization:
  - Each `DREQ` bit passes through `SYNC_STAGES` flip-flops.
  - The synchronized value `syncReq` is inverted when `dreqActiveLow`=1.
  - `dreqActiveLow` is applied after synchronization, so it takes effect combinationally.
- Mask register, 4 bits, reset value 4'b1111. Updates are applied in this order, and later updates override earlier ones for the same bit:
  1. A TC pulse on channel n with `autoinit[n]`=0 sets mask[n].
  2. `maskWrite` loads `maskData` into all four bits.
  3. `singleMaskWrite` writes mask[`singleMaskChannel`].
- Software request register, 4 bits, reset value 0:
  - `softReqWrite` writes softReq[`softReqChannel`].
  - A TC pulse on channel n clears softReq[n]. If a TC clear and a write hit the same bit in the same cycle, the clear wins.
- `reqVector` = (`syncReq` | softReq) & ~mask, forced to 0 while `controllerDisable`=1. It is combinational from registers and stays live in every FSM state.
- FSM states: IDLE, WAIT_HLDA, ACTIVE, RELEASE.
  - IDLE: HRQ=0, assertDACK=0. Goes to WAIT_HLDA when `reqVector` is nonzero.
  - WAIT_HLDA: HRQ=1. Goes to ACTIVE when `HLDA`=1. Goes back to IDLE if `reqVector` becomes 0 before HLDA arrives.
  - ACTIVE: HRQ=1, assertDACK=1. Goes to RELEASE on `transferDone`. Request changes during ACTIVE do not end the service.
  - RELEASE: HRQ=0, assertDACK=0. Goes to IDLE once `HLDA`=0.
- Setting `controllerDisable` forces the FSM to IDLE from any state except RELEASE, which still waits for `HLDA`=0.

## Timing
- Reset: on a `CLK` edge with `RESET`=1:
  - All synchronizer flops go to 0 and the FSM goes to IDLE.
  - HRQ=0, assertDACK=0, mask=4'b1111, softReq=0, so `reqVector`=`statusReq`=0.
  - Reset applied mid-service drops HRQ and assertDACK after that edge, whatever the state of HLDA.
- DREQ latency: a DREQ level change sampled at edge k shows on `reqVector` after edge k+`SYNC_STAGES`-1, provided it is unmasked.
- Software request and mask writes are visible on `reqVector` one edge after the write cycle.
- HRQ assertion: rises on the edge after `reqVector` first becomes nonzero in IDLE.
- HLDA to assertDACK: assertDACK rises on the edge after `HLDA` is sampled high in WAIT_HLDA.
- `transferDone` sampled high causes HRQ and assertDACK to drop on that same edge.
- HRQ cannot re-assert until the FSM has passed through RELEASE with `HLDA`=0 and then IDLE. The minimum gap is 2 cycles.
- TC with autoinit: when `autoinit[n]`=1 a TC pulse leaves mask[n] unchanged but still clears softReq[n].

## Test plan
- Reset, then clear the mask with `maskWrite`=1, `maskData`=0. Drive `DREQ`=4'b0100 with `dreqActiveLow`=0 -> `reqVector`=4'b0100 two edges later, HRQ=1 one edge after that; `HLDA`=1 -> assertDACK=1 on the next edge; `transferDone` pulse -> HRQ=0 and assertDACK=0; `HLDA`=0 -> IDLE.
- Reset with `DREQ`=4'b1111 -> `reqVector`=0 and HRQ=0, because all channels are masked; `singleMaskWrite` on channel 3 with bit 0 -> `reqVector`=4'b1000.
- Masks clear, `DREQ`=0, `softReqWrite` on channel 1 with bit 1 -> `reqVector`=4'b0010 on the next edge; `tcChannel`=4'b0010 with `autoinit`=0 -> softReq[1]=0 and mask[1]=1.
- `dreqActiveLow`=1 with `DREQ`=4'b1110 and masks clear -> `reqVector`=4'b0001; raise DREQ[0] in WAIT_HLDA before HLDA -> HRQ drops and the FSM returns to IDLE.
- In ACTIVE, assert `RESET` for 1 cycle with `HLDA` still 1 -> HRQ=0, assertDACK=0, mask=4'b1111 on the next edge.
- Same cycle: `tcChannel`=4'b0001 with `autoinit`=0, plus `singleMaskWrite` on channel 0 with bit 0 -> mask[0]=0, because the explicit write wins.
